// File: rtl/mux4_pkg.sv
// Shared definitions for the four-channel round-robin mux feeder.
package mux4_pkg;

  localparam int unsigned CH_N      = 4;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned WIDTH_DEF = 16;

  // Reset value of the last-served channel, so the first scan starts at ch0.
  localparam logic [CH_W-1:0] LAST_RST = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning upward from start with wrap.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  logic [CH_W-1:0] start,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  // Scan the four positions starting at start, keep the first requester.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx   = '0;
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < CH_N; i++) begin
      idx = start + CH_W'(i);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_feeder.sv
// Buffered four-channel word sequencer feeding a 4:1 mux with a registered select.
// Optional overwrite counter enabled by defining MUX4_RR_OVF_CNT_EN.
module mux4_rr_feeder
  import mux4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] word0,
  output logic [WIDTH-1:0] word1,
  output logic [WIDTH-1:0] word2,
  output logic [WIDTH-1:0] word3,
  output logic [CH_W-1:0]  sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic             ovf
`ifdef MUX4_RR_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] words_q [CH_N];
  logic [WIDTH-1:0] words_d [CH_N];
  logic [CH_N-1:0]  pending_q, pending_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
`ifdef MUX4_RR_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
`endif

  logic             wr_acc;
  logic             ovf_evt;
  logic             hs;
  logic [CH_N-1:0]  wr_mask;
  logic [CH_N-1:0]  pend_rem;
  logic [CH_W-1:0]  idle_grant, next_grant;
  logic             idle_any, next_any;

  // The presented word is frozen: writes to the selected channel are refused while valid.
  assign in_ready = !(out_valid_q && (in_ch == sel_q));

  // Write decode, handshake and the pending set left after serving sel.
  always_comb begin
    wr_acc   = in_valid && in_ready;
    wr_mask  = wr_acc ? (CH_N'(1) << in_ch) : '0;
    ovf_evt  = wr_acc && pending_q[in_ch];
    hs       = out_valid_q && out_ready;
    pend_rem = (pending_q | wr_mask) & ~(CH_N'(1) << sel_q);
  end

  rr_pick4 u_pick_idle (
    .req   (pending_q),
    .start (last_q + CH_W'(1)),
    .grant (idle_grant),
    .any   (idle_any)
  );

  rr_pick4 u_pick_next (
    .req   (pend_rem),
    .start (sel_q + CH_W'(1)),
    .grant (next_grant),
    .any   (next_any)
  );

  // Next-state: word store, pending bookkeeping and the IDLE/PRESENT scheduler.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    words_d     = words_q;
    pending_d   = pending_q | wr_mask;
    ovf_d       = ovf_q | ovf_evt;
    if (wr_acc) begin
      words_d[in_ch] = in_data;
    end
    unique case (state_q)
      IDLE: begin
        if (idle_any) begin
          sel_d       = idle_grant;
          state_d     = PRESENT;
          out_valid_d = 1'b1;
        end
      end
      PRESENT: begin
        if (hs) begin
          pending_d[sel_q] = 1'b0;
          last_d           = sel_q;
          if (next_any) begin
            sel_d = next_grant;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef MUX4_RR_OVF_CNT_EN
  // Saturating count of overwrite events.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_evt && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end
`endif

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      sel_q       <= '0;
      last_q      <= LAST_RST;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int unsigned i = 0; i < CH_N; i++) begin
        words_q[i] <= '0;
      end
`ifdef MUX4_RR_OVF_CNT_EN
      ovf_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      words_q     <= words_d;
`ifdef MUX4_RR_OVF_CNT_EN
      ovf_cnt_q   <= ovf_cnt_d;
`endif
    end
  end

  assign word0     = words_q[0];
  assign word1     = words_q[1];
  assign word2     = words_q[2];
  assign word3     = words_q[3];
  assign sel       = sel_q;
  assign out_ch    = sel_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
`ifdef MUX4_RR_OVF_CNT_EN
  assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Scoreboard bench for mux4_rr_feeder; the downstream 4:1 mux is modelled inline.
module tb_mux4_rr_feeder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] word0, word1, word2, word3;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic        ovf;
`ifdef MUX4_RR_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif
  logic [15:0] mux_out;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mux4_rr_feeder #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .word0     (word0),
    .word1     (word1),
    .word2     (word2),
    .word3     (word3),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .ovf       (ovf)
`ifdef MUX4_RR_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always_comb begin
    case (sel)
      2'd0:    mux_out = word0;
      2'd1:    mux_out = word1;
      2'd2:    mux_out = word2;
      default: mux_out = word3;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one write at posedge+1; optionally check in_ready before the edge.
  task automatic wr(input logic [1:0] ch, input logic [15:0] d, input bit chk, input logic exp_rdy);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    #1;
    if (chk) check_eq("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [15:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain_left", sb.size(), 0);
    check_eq("drain_idle", out_valid, 1'b0);
  endtask

  // Consumer side: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexp_word", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_ch", out_ch, e.ch);
        check_eq("mux_data", mux_out, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = 2'd0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_sel", sel, 2'd0);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_word0", word0, 16'h0);
    check_eq("rst_last", dut.last_q, 2'd3);
    check_eq("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, consumer always ready.
    push(2'd2, 16'hBEEF);
    wr(2'd2, 16'hBEEF, 1'b1, 1'b1);
    check_eq("t1_lat0", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_sel", sel, 2'd2);
    check_eq("t1_word2", word2, 16'hBEEF);
    @(posedge clk);
    #1;
    check_eq("t1_idle", out_valid, 1'b0);
    check_eq("t1_pend", dut.pending_q, 4'h0);

    // Three writes held back, then back-to-back service 0,1,3.
    out_ready = 1'b0;
    push(2'd0, 16'h0001); push(2'd1, 16'h0002); push(2'd3, 16'h0003);
    wr(2'd0, 16'h0001, 1'b0, 1'b1);
    wr(2'd1, 16'h0002, 1'b0, 1'b1);
    wr(2'd3, 16'h0003, 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_b2b", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    check_eq("t2_drop", out_valid, 1'b0);

    // Make last=1, then all four pending: expect 2,3,0,1.
    push(2'd1, 16'h0B01);
    wr(2'd1, 16'h0B01, 1'b0, 1'b1);
    drain();
    out_ready = 1'b0;
    push(2'd2, 16'hC002); push(2'd3, 16'hC003); push(2'd0, 16'hC000); push(2'd1, 16'hC001);
    wr(2'd2, 16'hC002, 1'b0, 1'b1);
    wr(2'd0, 16'hC000, 1'b0, 1'b1);
    wr(2'd1, 16'hC001, 1'b0, 1'b1);
    wr(2'd3, 16'hC003, 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_b2b", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    check_eq("t3_drop", out_valid, 1'b0);

    // Write to the presented channel is refused; another channel is accepted.
    out_ready = 1'b0;
    push(2'd1, 16'hAAAA);
    wr(2'd1, 16'hAAAA, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_eq("t4_sel", sel, 2'd1);
    wr(2'd1, 16'h5555, 1'b1, 1'b0);
    check_eq("t4_word1", word1, 16'hAAAA);
    push(2'd3, 16'h3333);
    wr(2'd3, 16'h3333, 1'b1, 1'b1);
    out_ready = 1'b1;
    drain();

    // Overwrite of a pending channel while another is presented.
    check_eq("t5_ovf0", ovf, 1'b0);
    out_ready = 1'b0;
    push(2'd2, 16'h2020);
    wr(2'd2, 16'h2020, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    wr(2'd0, 16'h1111, 1'b1, 1'b1);
    wr(2'd0, 16'h2222, 1'b1, 1'b1);
    check_eq("t5_ovf1", ovf, 1'b1);
`ifdef MUX4_RR_OVF_CNT_EN
    check_eq("t5_cnt1", ovf_cnt, 8'd1);
    for (int i = 0; i < 299; i++) begin
      wr(2'd0, 16'(i), 1'b0, 1'b1);
    end
    check_eq("t5_cnt_sat", ovf_cnt, 8'd255);
    push(2'd0, 16'd298);
`else
    push(2'd0, 16'h2222);
`endif
    out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of PRESENT with three pending.
    out_ready = 1'b0;
    wr(2'd1, 16'h0101, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    wr(2'd2, 16'h0202, 1'b0, 1'b1);
    wr(2'd3, 16'h0303, 1'b0, 1'b1);
    check_eq("t6_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", out_valid, 1'b0);
    check_eq("t6_pend", dut.pending_q, 4'h0);
    check_eq("t6_ovf", ovf, 1'b0);
    check_eq("t6_words", {word0, word1, word2, word3} == 64'h0, 1'b1);
    check_eq("t6_last", dut.last_q, 2'd3);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(2'd0, 16'h0F0F);
    wr(2'd0, 16'h0F0F, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
